// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: M:SS round timer kept as BCD digits, frame-strobe paced.
// Optional low-time warning output built only when TIMER_WARN_EN is defined.
module bcd_countdown_timer #(
    parameter int MIN_DIGITS = 1,
    parameter int TICK_DIV   = 60,
    parameter int START_MIN  = 2,
    parameter int START_SEC  = 0,
    parameter int WARN_SEC   = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    count_up,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    load,
    input  logic [4*MIN_DIGITS-1:0] load_min,
    input  logic [7:0]              load_sec,
    output logic [4*MIN_DIGITS-1:0] min_bcd,
    output logic [7:0]              sec_bcd,
    output logic                    running,
    output logic                    expired,
    output logic                    expired_pulse,
    output logic                    warn
);

    localparam int MW = 4 * MIN_DIGITS;
    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    function automatic logic [MW-1:0] min_rst(input int v);
        logic [7:0] t;
        t = {4'((v / 10) % 10), 4'(v % 10)};
        return t[MW-1:0];
    endfunction

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    localparam logic [MW-1:0] RST_MIN = min_rst(START_MIN);
    localparam logic [7:0] RST_SEC =
        {4'(START_SEC / 10), 4'(START_SEC % 10)};
    localparam logic [MW-1:0] MAX_MIN = {MIN_DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    tick_q, tick_d;
    logic [MW-1:0] min_q, min_d;
    logic [7:0]    sec_q, sec_d;
    logic          running_q, running_d;
    logic          expired_q, expired_d;
    logic          pulse_q, pulse_d;

    logic [MW-1:0] dn_min, up_min, ld_min, step_min;
    logic [7:0]    dn_sec, up_sec, ld_sec, step_sec;
    logic          borrow, carry;
    logic          term_now, term_step;

    // One-second step in both directions, BCD borrow/carry chains.
    always_comb begin
        dn_min = min_q;
        dn_sec = sec_q;
        up_min = min_q;
        up_sec = sec_q;
        borrow = 1'b0;
        carry  = 1'b0;
        if (sec_q[3:0] != 4'd0) begin
            dn_sec[3:0] = sec_q[3:0] - 4'd1;
        end else begin
            dn_sec[3:0] = 4'd9;
            if (sec_q[7:4] != 4'd0) begin
                dn_sec[7:4] = sec_q[7:4] - 4'd1;
            end else begin
                dn_sec[7:4] = 4'd5;
                borrow = 1'b1;
            end
        end
        if (sec_q[3:0] != 4'd9) begin
            up_sec[3:0] = sec_q[3:0] + 4'd1;
        end else begin
            up_sec[3:0] = 4'd0;
            if (sec_q[7:4] != 4'd5) begin
                up_sec[7:4] = sec_q[7:4] + 4'd1;
            end else begin
                up_sec[7:4] = 4'd0;
                carry = 1'b1;
            end
        end
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (borrow) begin
                if (min_q[4*i +: 4] != 4'd0) begin
                    dn_min[4*i +: 4] = min_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end else begin
                    dn_min[4*i +: 4] = 4'd9;
                end
            end
            if (carry) begin
                if (min_q[4*i +: 4] != 4'd9) begin
                    up_min[4*i +: 4] = min_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end else begin
                    up_min[4*i +: 4] = 4'd0;
                end
            end
        end
    end

    // Direction select and terminal detection for the current mode.
    always_comb begin
        step_min = count_up ? up_min : dn_min;
        step_sec = count_up ? up_sec : dn_sec;
        if (count_up) begin
            term_now  = (min_q == MAX_MIN) && (sec_q == 8'h59);
            term_step = (step_min == MAX_MIN) && (step_sec == 8'h59);
        end else begin
            term_now  = (min_q == '0) && (sec_q == 8'h00);
            term_step = (step_min == '0) && (step_sec == 8'h00);
        end
    end

    // Load value with out-of-range digits clamped.
    always_comb begin
        ld_min = '0;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            ld_min[4*i +: 4] = clamp9(load_min[4*i +: 4]);
        end
        ld_sec[7:4] = (load_sec[7:4] > 4'd5) ? 4'd5 : load_sec[7:4];
        ld_sec[3:0] = clamp9(load_sec[3:0]);
    end

    // Next state, tick counter and value; load > pause > start > tick.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        min_d   = min_q;
        sec_d   = sec_q;
        if (load) begin
            state_d = IDLE;
            tick_d  = 8'd0;
            min_d   = ld_min;
            sec_d   = ld_sec;
        end else if (pause) begin
            if (state_q == RUN) state_d = PAUSED;
        end else if (start && (state_q == IDLE ||
                               state_q == PAUSED)) begin
            state_d = term_now ? EXPIRED : RUN;
        end else if (state_q == RUN && frame_tick) begin
            if (tick_q == TICK_LAST) begin
                tick_d = 8'd0;
                // A mode flip can leave RUN sitting on the terminal
                // value; expire there instead of wrapping around.
                if (term_now) begin
                    state_d = EXPIRED;
                end else begin
                    min_d = step_min;
                    sec_d = step_sec;
                    if (term_step) state_d = EXPIRED;
                end
            end else begin
                tick_d = tick_q + 8'd1;
            end
        end
        running_d = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
        pulse_d   = (state_d == EXPIRED) && (state_q != EXPIRED);
    end

    // State, value and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tick_q    <= 8'd0;
            min_q     <= RST_MIN;
            sec_q     <= RST_SEC;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            running_q <= running_d;
            expired_q <= expired_d;
            pulse_q   <= pulse_d;
        end
    end

    assign min_bcd       = min_q;
    assign sec_bcd       = sec_q;
    assign running       = running_q;
    assign expired       = expired_q;
    assign expired_pulse = pulse_q;

`ifdef TIMER_WARN_EN
    logic [6:0]  min_bin;
    logic [12:0] total;
    logic        warn_q, warn_d;

    // Remaining-seconds threshold on the value being registered.
    always_comb begin
        min_bin = '0;
        for (int i = MIN_DIGITS - 1; i >= 0; i--) begin
            min_bin = 7'(min_bin * 7'd10 + 7'(min_d[4*i +: 4]));
        end
        total = 13'(min_bin) * 13'd60
              + 13'(sec_d[7:4]) * 13'd10
              + 13'(sec_d[3:0]);
        warn_d = (state_d == RUN || state_d == PAUSED)
              && !count_up
              && (total <= 13'(WARN_SEC));
    end

    // Warning register.
    always_ff @(posedge clk) begin
        if (reset) warn_q <= 1'b0;
        else       warn_q <= warn_d;
    end

    assign warn = warn_q;
`else
    // Threshold only matters when the warning logic is built.
    assign warn = 1'b0 && (WARN_SEC > 0);
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: directed + random stimulus against a
// seconds-arithmetic reference model of the M:SS timer.
module tb_bcd_countdown_timer;

    localparam int TD = 60;
    localparam int MAXT = 9 * 60 + 59;
`ifdef TIMER_WARN_EN
    localparam bit W_ON = 1'b1;
`else
    localparam bit W_ON = 1'b0;
`endif

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_PAU  = 2;
    localparam int S_EXP  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       count_up = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_min = 4'h0;
    logic [7:0] load_sec = 8'h00;
    logic [3:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running, expired, expired_pulse, warn;

    int n_cmp = 0;
    int n_bad = 0;

    int m_st = S_IDLE;
    int m_tot = 120;
    int m_tick = 0;
    bit m_pulse = 1'b0;
    bit m_warn = 1'b0;

    logic [15:0] obs;

    bcd_countdown_timer #(
        .MIN_DIGITS(1), .TICK_DIV(TD),
        .START_MIN(2), .START_SEC(0), .WARN_SEC(10)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .count_up(count_up), .start(start), .pause(pause),
        .load(load), .load_min(load_min), .load_sec(load_sec),
        .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running),
        .expired(expired), .expired_pulse(expired_pulse),
        .warn(warn)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic bit is_term(input int t, input bit up);
        return up ? (t == MAXT) : (t == 0);
    endfunction

    function automatic logic [15:0] model_vec();
        return {4'(m_tot / 60), bcd8(m_tot % 60),
                m_st == S_RUN, m_st == S_EXP, m_pulse, m_warn};
    endfunction

    task automatic chk(input string tag, input logic [15:0] o,
                       input logic [15:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, o, e);
        end
    endtask

    // Reference model: time kept as total seconds.
    task automatic model_step();
        int m, s;
        m_pulse = 1'b0;
        if (reset) begin
            m_st = S_IDLE; m_tot = 120; m_tick = 0;
        end else if (load) begin
            m = (load_min > 9) ? 9 : int'(load_min);
            s = ((load_sec[7:4] > 5) ? 5 : int'(load_sec[7:4])) * 10
              + ((load_sec[3:0] > 9) ? 9 : int'(load_sec[3:0]));
            m_tot = m * 60 + s; m_st = S_IDLE; m_tick = 0;
        end else if (pause) begin
            if (m_st == S_RUN) m_st = S_PAU;
        end else if (start && (m_st == S_IDLE || m_st == S_PAU)) begin
            if (is_term(m_tot, count_up)) begin
                m_st = S_EXP; m_pulse = 1'b1;
            end else begin
                m_st = S_RUN;
            end
        end else if (m_st == S_RUN && frame_tick) begin
            m_tick++;
            if (m_tick == TD) begin
                m_tick = 0;
                if (is_term(m_tot, count_up)) begin
                    m_st = S_EXP; m_pulse = 1'b1;
                end else begin
                    m_tot = count_up ? m_tot + 1 : m_tot - 1;
                    if (is_term(m_tot, count_up)) begin
                        m_st = S_EXP; m_pulse = 1'b1;
                    end
                end
            end
        end
        m_warn = W_ON && (m_st == S_RUN || m_st == S_PAU)
                 && !count_up && (m_tot <= 10);
    endtask

    task automatic cyc(input bit ft, input bit st, input bit ps,
                       input bit ld);
        frame_tick = ft; start = st; pause = ps; load = ld;
        model_step();
        @(posedge clk);
        #1;
        obs = {min_bcd, sec_bcd, running, expired, expired_pulse, warn};
        chk("model", obs, model_vec());
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
    endtask

    task automatic do_load(input logic [3:0] m, input logic [7:0] s);
        load_min = m; load_sec = s;
        cyc(0, 0, 0, 1);
    endtask

    initial begin
        int r;
        #2;
        reset = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        reset = 1'b0;
        chk("reset", obs, {4'h2, 8'h00, 4'b0000});

        cyc(0, 1, 0, 0);
        pulses(59);
        chk("2:00 hold", obs, {4'h2, 8'h00, 4'b1000});
        pulses(1);
        chk("1:59", obs, {4'h1, 8'h59, 4'b1000});

        do_load(4'h1, 8'h00);
        cyc(0, 1, 0, 0);
        pulses(60);
        chk("borrow 0:59", obs, {4'h0, 8'h59, 4'b1000});
        do_load(4'h0, 8'h10);
        cyc(0, 1, 0, 0);
        pulses(60);
        chk("borrow 0:09", obs, {4'h0, 8'h09, 4'b1000});

        do_load(4'h0, 8'h01);
        cyc(0, 1, 0, 0);
        pulses(59);
        cyc(1, 0, 0, 0);
        chk("expire edge", obs, {4'h0, 8'h00, 4'b0110});
        cyc(0, 0, 0, 0);
        chk("pulse once", obs, {4'h0, 8'h00, 4'b0100});
        pulses(20);
        chk("no underflow", obs, {4'h0, 8'h00, 4'b0100});

        do_load(4'h0, 8'h30);
        cyc(0, 1, 0, 0);
        pulses(30);
        cyc(0, 0, 1, 0);
        pulses(100);
        chk("paused hold", obs, {4'h0, 8'h30, 4'b0000});
        cyc(0, 1, 0, 0);
        pulses(29);
        chk("resume 29", obs, {4'h0, 8'h30, 4'b1000});
        pulses(1);
        chk("resume 30", obs, {4'h0, 8'h29, 4'b1000});

        count_up = 1'b1;
        do_load(4'h9, 8'h58);
        cyc(0, 1, 0, 0);
        pulses(59);
        cyc(1, 0, 0, 0);
        chk("up 9:59 exp", obs, {4'h9, 8'h59, 4'b0110});
        pulses(60);
        chk("up saturate", obs, {4'h9, 8'h59, 4'b0100});

        do_load(4'hC, 8'h7C);
        chk("clamp", obs, {4'h9, 8'h59, 4'b0000});
        cyc(0, 1, 0, 0);
        chk("start at term", obs, {4'h9, 8'h59, 4'b0110});

        count_up = 1'b0;
        do_load(4'h0, 8'h12);
        cyc(0, 1, 0, 0);
        pulses(60);
        chk("warn 0:11", obs, {4'h0, 8'h11, 4'b1000});
        pulses(60);
        chk("warn 0:10", obs, {4'h0, 8'h10, 3'b100, W_ON});
        pulses(599);
        cyc(1, 0, 0, 0);
        chk("warn at exp", obs, {4'h0, 8'h00, 4'b0110});
        do_load(4'h0, 8'h05);
        cyc(0, 1, 0, 0);
        chk("warn 0:05", obs, {4'h0, 8'h05, 3'b100, W_ON});
        do_load(4'h1, 8'h00);
        chk("warn load", obs, {4'h1, 8'h00, 4'b0000});

        for (int i = 0; i < 6000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 3) count_up = ~count_up;
            if (r >= 3 && r < 8) begin
                load_min = 4'($urandom_range(0, 15));
                if (r < 6) load_sec = 8'($urandom_range(0, 3));
                else       load_sec = 8'($urandom_range(0, 255));
                cyc(0, 0, 0, 1);
            end else begin
                cyc($urandom_range(0, 9) < 7,
                    $urandom_range(0, 99) < 4,
                    $urandom_range(0, 99) < 2, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
